// File: rtl/present_dec.sv
// Iterative PRESENT-80 decryption core. It expands the user key forward to K32
// (unless K32 is supplied), then runs one inverse round per clock back to K1.
module present_dec #(
  parameter int KEY_IS_LAST = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] cipher,
  input  logic [79:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plain,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, KEYEXP, WHITEN, DECRYPT, DONE} state_t;

  // Nibble tables stored with index 0 in the most significant nibble.
  localparam logic [63:0] SBOX     = 64'hC56B90AD3EF84712;
  localparam logic [63:0] SBOX_INV = 64'h5EF8C12DB463079A;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX[{~x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    return SBOX_INV[{~x, 2'b00} +: 4];
  endfunction

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [63:0] st_reg, st_next;
  logic [79:0] k_reg, k_next;

  logic [79:0] k_rot, k_fwd, k_x, kp;
  logic [63:0] st_p, st_s, st_dec;

  always_comb begin
    k_rot        = {k_reg[18:0], k_reg[79:19]};
    k_fwd        = k_rot;
    k_fwd[79:76] = sbox(k_rot[79:76]);
    k_fwd[19:15] = k_rot[19:15] ^ cnt_reg;

    // Undo the forward key update step by step in reverse order.
    k_x          = k_reg;
    k_x[19:15]   = k_reg[19:15] ^ cnt_reg;
    k_x[79:76]   = sbox_inv(k_x[79:76]);
    kp           = {k_x[60:0], k_x[79:61]};
  end

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_pinv
      if (gi == 63) begin : g_fixed
        assign st_p[gi] = st_reg[63];
      end else begin : g_move
        assign st_p[gi] = st_reg[(gi * 16) % 63];
      end
    end
    for (gi = 0; gi < 16; gi++) begin : g_sinv
      assign st_s[gi*4 +: 4] = sbox_inv(st_p[gi*4 +: 4]);
    end
  endgenerate

  assign st_dec = st_s ^ kp[79:16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      st_reg    <= '0;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      st_reg    <= st_next;
      k_reg     <= k_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    st_next    = st_reg;
    k_next     = k_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          st_next = cipher;
          k_next  = key;
          if (KEY_IS_LAST != 0) begin
            state_next = WHITEN;
          end else begin
            cnt_next   = 5'd1;
            state_next = KEYEXP;
          end
        end
      end
      KEYEXP: begin
        k_next = k_fwd;
        // Hold the counter at 31 on the last expansion step so it never wraps.
        if (cnt_reg == 5'd31) begin
          state_next = WHITEN;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      WHITEN: begin
        st_next    = st_reg ^ k_reg[79:16];
        cnt_next   = 5'd31;
        state_next = DECRYPT;
      end
      DECRYPT: begin
        st_next = st_dec;
        k_next  = kp;
        if (cnt_reg == 5'd1) begin
          cnt_next   = 5'd0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 5'd1;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg == KEYEXP) || (state_reg == WHITEN) || (state_reg == DECRYPT);
  assign out_valid = (state_reg == DONE);
  assign plain     = st_reg;

endmodule

// File: tb/tb_present_dec.sv
// Bench for present_dec: a cycle-level behavioural model plus a PRESENT reference
// cipher, checked every cycle, with directed vectors and a random round-trip run.
module tb_present_dec;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] cipher = '0;
  logic [79:0] key = '0;
  logic        in_ready, out_valid, busy;
  logic [63:0] plain;

  logic        in_valid_l = 1'b0;
  logic        out_ready_l = 1'b0;
  logic [63:0] cipher_l = '0;
  logic [79:0] key_l = '0;
  logic        in_ready_l, out_valid_l, busy_l;
  logic [63:0] plain_l;

  always #5 clk = ~clk;

  present_dec #(.KEY_IS_LAST(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cipher(cipher), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .plain(plain), .busy(busy)
  );

  present_dec #(.KEY_IS_LAST(1)) dut_last (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_l), .in_ready(in_ready_l),
    .cipher(cipher_l), .key(key_l), .out_valid(out_valid_l), .out_ready(out_ready_l),
    .plain(plain_l), .busy(busy_l)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference cipher ----------------
  int sb[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
  int sbi[16];

  function automatic logic [63:0] sub(input logic [63:0] x, input bit inv);
    logic [63:0] y;
    logic [3:0]  v;
    for (int n = 0; n < 16; n++) begin
      v = x[4*n +: 4];
      y[4*n +: 4] = inv ? 4'(sbi[v]) : 4'(sb[v]);
    end
    return y;
  endfunction

  // Bit i moves to position 16*i mod 63; applying it three times is the identity.
  function automatic logic [63:0] perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[(i == 63) ? 63 : (16 * i) % 63] = x[i];
    return y;
  endfunction

  function automatic logic [79:0] key_step(input logic [79:0] k, input int i);
    k = {k[18:0], k[79:19]};
    k[79:76] = 4'(sb[k[79:76]]);
    k[19:15] = k[19:15] ^ 5'(i);
    return k;
  endfunction

  function automatic logic [79:0] key_last(input logic [79:0] k);
    for (int i = 1; i <= 31; i++) k = key_step(k, i);
    return k;
  endfunction

  function automatic logic [63:0] encrypt(input logic [63:0] p, input logic [79:0] k);
    logic [63:0] s;
    s = p;
    for (int i = 1; i <= 31; i++) begin
      s = perm(sub(s ^ k[79:16], 1'b0));
      k = key_step(k, i);
    end
    return s ^ k[79:16];
  endfunction

  function automatic logic [63:0] decrypt(input logic [63:0] c, input logic [79:0] k);
    logic [63:0] rk [1:32];
    logic [63:0] s;
    rk[1] = k[79:16];
    for (int i = 1; i <= 31; i++) begin
      k = key_step(k, i);
      rk[i+1] = k[79:16];
    end
    s = c ^ rk[32];
    for (int i = 31; i >= 1; i--) s = sub(perm(perm(s)), 1'b1) ^ rk[i];
    return s;
  endfunction

  // ---------------- cycle model of the handshake ----------------
  int          ph = 0;        // 0 waiting for a job, 1 computing, 2 result held
  int          rem = 0;
  logic [63:0] m_plain = '0;
  logic [63:0] m_pend = '0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  logic [63:0] want_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph      <= 0;
      rem     <= 0;
      m_plain <= '0;
      want_q.delete();
    end else begin
      case (ph)
        0: if (in_valid) begin
          m_pend  <= decrypt(cipher, key);
          ph      <= 1;
          rem     <= 63;
          acc_cnt <= acc_cnt + 1;
        end
        1: begin
          rem <= rem - 1;
          if (rem == 1) begin
            ph      <= 2;
            m_plain <= m_pend;
          end
        end
        default: if (out_ready) begin
          ph       <= 0;
          done_cnt <= done_cnt + 1;
        end
      endcase
    end
  end

  int txn = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk_b("in_ready", in_ready, ph == 0);
      chk_b("busy", busy, ph == 1);
      chk_b("out_valid", out_valid, ph == 2);
      if (ph != 1) chk_w("plain_model", plain, m_plain);
      if (ph == 2 && out_ready) begin
        txn++;
        if (want_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dup_result: got %h want none queued", plain);
        end else begin
          chk_w("result", plain, want_q.pop_front());
        end
        $display("txn %0d plain=%h", txn, plain);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed helpers (called #1 after a rising edge) ----------------
  task automatic submit(input logic [63:0] c, input logic [79:0] k, input logic [63:0] exp);
    int n;
    int a0;
    n = 0;
    a0 = acc_cnt;
    cipher = c;
    key = k;
    in_valid = 1'b1;
    while (acc_cnt == a0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (acc_cnt == a0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept want accept within 500 cycles");
    end else begin
      want_q.push_back(exp);
    end
    in_valid = 1'b0;
    cipher = {$urandom, $urandom};
    key = {$urandom, $urandom, 16'($urandom)};
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk_i(name, lat, exp_lat);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int a_last;
    int d_start;
    int sent;
    logic [63:0] p;
    logic [79:0] k;

    for (int v = 0; v < 16; v++) sbi[sb[v]] = v;

    // Pin the reference cipher to published vectors.
    chk_w("ref_enc_0_0", encrypt(64'h0, 80'h0), 64'h5579C1387B228445);
    chk_w("ref_dec_0_0", decrypt(64'h5579C1387B228445, 80'h0), 64'h0);
    chk_w("ref_dec_f_0", decrypt(64'hA112FFC72F68417B, 80'h0), 64'hFFFFFFFFFFFFFFFF);
    chk_w("ref_enc_f_f", encrypt(64'hFFFFFFFFFFFFFFFF, {80{1'b1}}), 64'h3333DCD3213210D2);

    repeat (3) @(posedge clk);
    #1;
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_w("rst_plain", plain, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_b("rst_in_ready", in_ready, 1'b1);

    // Known-answer jobs with latency.
    submit(64'h5579C1387B228445, 80'h0, 64'h0);
    wait_done("latency_63", 63);
    chk_w("kat0_plain", plain, 64'h0);
    release_result();
    submit(64'hE72C46C0F5945049, {80{1'b1}}, 64'h0);
    wait_done("latency_b", 63);
    release_result();
    submit(64'hA112FFC72F68417B, 80'h0, 64'hFFFFFFFFFFFFFFFF);
    wait_done("latency_c", 63);
    chk_w("kat2_plain", plain, 64'hFFFFFFFFFFFFFFFF);
    release_result();
    submit(64'h3333DCD3213210D2, {80{1'b1}}, 64'hFFFFFFFFFFFFFFFF);
    wait_done("latency_d", 63);
    release_result();

    // Backpressure and ignored input pulses.
    submit(64'h5579C1387B228445, 80'h0, 64'h0);
    for (int i = 1; i <= 63; i++) begin
      in_valid = (i == 10 || i == 30);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk_b("bp_valid_start", out_valid, 1'b1);
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 3 == 0);
      @(posedge clk); #1;
      chk_b("bp_valid_hold", out_valid, 1'b1);
      chk_b("bp_no_ready", in_ready, 1'b0);
      chk_w("bp_plain_hold", plain, 64'h0);
    end
    in_valid = 1'b0;
    release_result();
    chk_b("bp_idle_after", in_ready, 1'b1);
    chk_b("bp_valid_drop", out_valid, 1'b0);
    submit(64'hA112FFC72F68417B, 80'h0, 64'hFFFFFFFFFFFFFFFF);
    wait_done("latency_bp", 63);
    release_result();
    chk_w("plain_kept", plain, 64'hFFFFFFFFFFFFFFFF);

    // Reset in the middle of a job.
    submit(64'hE72C46C0F5945049, {80{1'b1}}, 64'h0);
    repeat (39) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk_b("abort_out_valid", out_valid, 1'b0);
    chk_b("abort_busy", busy, 1'b0);
    chk_w("abort_plain", plain, 64'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    submit(64'h3333DCD3213210D2, {80{1'b1}}, 64'hFFFFFFFFFFFFFFFF);
    wait_done("latency_post_reset", 63);
    release_result();

    // Core that takes K32 directly.
    for (int j = 0; j < 2; j++) begin
      chk_b("last_in_ready", in_ready_l, 1'b1);
      cipher_l = (j == 0) ? 64'h5579C1387B228445 : 64'hE72C46C0F5945049;
      key_l = key_last((j == 0) ? 80'h0 : {80{1'b1}});
      in_valid_l = 1'b1;
      @(posedge clk); #1;
      in_valid_l = 1'b0;
      cipher_l = '1;
      key_l = '0;
      lat = 0;
      while (!out_valid_l && lat < 200) begin
        @(posedge clk); #1;
        lat++;
      end
      chk_i("last_latency_32", lat, 32);
      chk_w("last_plain", plain_l, 64'h0);
      chk_b("last_not_busy", busy_l, 1'b0);
      out_ready_l = 1'b1;
      @(posedge clk); #1;
      out_ready_l = 1'b0;
      chk_b("last_back_idle", in_ready_l, 1'b1);
      $display("txn last_key %0d plain=%h latency=%0d", j, plain_l, lat);
    end

    // Random round trips, back to back, random result backpressure.
    d_start = done_cnt;
    a_last = acc_cnt;
    sent = 0;
    p = {$urandom, $urandom};
    k = {$urandom, $urandom, 16'($urandom)};
    cipher = encrypt(p, k);
    key = k;
    in_valid = 1'b1;
    for (int it = 0; it < 90000 && (done_cnt - d_start) < 1000; it++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      if (acc_cnt != a_last) begin
        a_last = acc_cnt;
        want_q.push_back(p);
        sent++;
        if (sent < 1000) begin
          p = {$urandom, $urandom};
          k = {$urandom, $urandom, 16'($urandom)};
          cipher = encrypt(p, k);
          key = k;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk_i("random_sent", sent, 1000);
    chk_i("random_done", done_cnt - d_start, 1000);
    chk_i("queue_empty", want_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
